muxn_arb_reg: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It is the successor to the plain 4:1 behavioural mux. The channel is chosen either by a fixed select or by a round-robin arbiter. The result is captured in a single-entry output register. It sits between multiple producer streams and one consumer in datapath and bus-funnel logic.

---
 rtl/muxn_pkg.sv | 12 +
 rtl/muxn_arb_reg_rr_arbiter.sv | 59 +++++
 rtl/muxn_arb_reg.sv | 123 ++++++++++++
 tb/tb_muxn_arb_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// muxn_pkg: shared definitions for the muxn_arb_reg registered N:1 mux.
//   mode_e : channel-selection mode driven on the top-level 'mode' pin
//            MODE_FIXED (1'b0) -> channel taken from ctrl_sel
//            MODE_RR    (1'b1) -> channel chosen by the round-robin arbiter
package muxn_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/muxn_arb_reg_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over NUM_CH requesters.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointer -> 0)
//   req          : per-channel request vector
//   accept       : strobe, the current grant was consumed this cycle
//   grant        : one-hot grant (all zero when nothing requests)
//   grant_idx    : index of the granted channel
//   grant_valid  : some channel is granted
// Search order starts at the pointer and wraps modulo NUM_CH. The pointer
// moves to the channel after the winner only when 'accept' is high, so a
// stalled grant keeps its priority.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [SEL_W-1:0] ptr;

  // Channel 'off' steps after 'base', wrapping at NUM_CH (not 2**SEL_W,
  // because NUM_CH need not be a power of two). base < NUM_CH always.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return SEL_W'(s);
  endfunction

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        grant_idx   = wrap_idx(ptr, k);
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && grant_valid) begin
      ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/muxn_arb_reg.sv
// muxn_arb_reg: NUM_CH-channel, DATA_W-bit registered multiplexer with
// valid/ready on every input and on the output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   mode        : 0 = fixed select (ctrl_sel), 1 = round-robin
//   ctrl_sel    : channel used in fixed mode (>= NUM_CH selects nothing)
//   in_valid    : per-channel valid
//   in_data     : packed data, channel i at [i*DATA_W +: DATA_W]
//   in_ready    : per-channel ready, one-hot or zero
//   out_valid   : output register holds an item
//   out_data    : registered data
//   out_ch      : channel that supplied out_data
//   out_par     : even parity of out_data (only with MUXN_PARITY_EN defined)
//   out_ready   : consumer accepts
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high on the same interface. Producers must hold valid/data until
// that edge; ready is a function of the grant and the output register's
// state only, so it never waits on a channel's own valid beyond grant.
// The output register loads whenever it is empty or being drained
// (load_en), which gives 1-cycle latency and full throughput.
// Optional feature macro: MUXN_PARITY_EN.
module muxn_arb_reg
  import muxn_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         ctrl_sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
`ifdef MUXN_PARITY_EN
  output logic                     out_par,
`endif
  input  logic                     out_ready
);

  mode_e             mode_sel;
  logic [NUM_CH-1:0] fix_grant, rr_grant, grant;
  logic [SEL_W-1:0]  rr_idx, grant_idx;
  logic              fix_valid, rr_valid, grant_valid;
  logic              load_en, xfer;
  logic [DATA_W-1:0] sel_data;

  assign mode_sel = mode_e'(mode);

  // Fixed select: decode by comparison so an out-of-range ctrl_sel
  // simply matches no channel.
  always_comb begin
    fix_grant = '0;
    fix_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ctrl_sel == SEL_W'(i) && in_valid[i]) begin
        fix_grant[i] = 1'b1;
        fix_valid    = 1'b1;
      end
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .accept      (xfer && mode_sel == MODE_RR),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  always_comb begin
    if (mode_sel == MODE_RR) begin
      grant       = rr_grant;
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      grant       = fix_grant;
      grant_idx   = ctrl_sel;
      grant_valid = fix_valid;
    end
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_valid;
  // rst_n gate keeps ready low during reset even though load_en is high.
  assign in_ready = grant & {NUM_CH{load_en && rst_n}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
`ifdef MUXN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (load_en) begin
      // Draining with nothing granted empties the register; a grant
      // replaces the old item in the same edge.
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= sel_data;
        out_ch   <= grant_idx;
`ifdef MUXN_PARITY_EN
        out_par  <= ^sel_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb_reg.sv
// Self-checking bench for muxn_arb_reg: directed scenarios plus random
// traffic on a 4-channel instance, and a 3-channel instance for the
// out-of-range fixed select case.
module tb_muxn_arb_reg;
  import muxn_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int W      = SEL_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic                     mode = 1'b0;
  logic [SEL_W-1:0]         ctrl_sel = '0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready = 1'b0;

  // 3-channel DUT signals
  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [2:0]  valid3 = '0;
  logic [23:0] data3 = '0;
  logic [2:0]  ready3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  oc3;
  logic        or3 = 1'b0;
`ifdef MUXN_PARITY_EN
  logic out_par;
  logic out_par3;
`endif

  muxn_arb_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ctrl_sel(ctrl_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
`ifdef MUXN_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready)
  );

  muxn_arb_reg #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .ctrl_sel(sel3),
    .in_valid(valid3), .in_data(data3), .in_ready(ready3),
    .out_valid(ov3), .out_data(od3), .out_ch(oc3),
`ifdef MUXN_PARITY_EN
    .out_par(out_par3),
`endif
    .out_ready(or3)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit model_full = 1'b0;
  int model_ptr  = 0;
  bit mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference grant: the channel the rules pick, or -1 for none.
  function automatic int model_grant(input bit m, input int sel,
                                     input logic [NUM_CH-1:0] v, input int ptr);
    if (m == MODE_FIXED) return (sel < NUM_CH && v[sel]) ? sel : -1;
    for (int k = 0; k < NUM_CH; k++)
      if (v[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    return -1;
  endfunction

  // Driver: one cycle of stimulus. Inputs change at negedge+1; the
  // reference model runs at negedge+3, after the monitor has looked at
  // the register contents produced by the previous edge.
  task automatic drive_cycle(input bit m, input int sel,
                             input logic [NUM_CH-1:0] v,
                             input logic [NUM_CH*DATA_W-1:0] d, input bit rdy);
    int g;
    bit le;
    logic [NUM_CH-1:0] exp_rdy;
    @(negedge clk);
    #1;
    mode = m; ctrl_sel = SEL_W'(sel); in_valid = v; in_data = d; out_ready = rdy;
    #2;
    le = !model_full || rdy;
    g  = model_grant(m, sel, v, model_ptr);
    exp_rdy = (le && g >= 0) ? (NUM_CH'(1) << g) : '0;
    check("in_ready", in_ready, exp_rdy);
    if (le && g >= 0) begin
      exp_q.push_back({SEL_W'(g), d[g*DATA_W +: DATA_W]});
      model_full = 1'b1;
      if (m == MODE_RR) model_ptr = (g + 1) % NUM_CH;
    end else if (le) begin
      model_full = 1'b0;
    end
  endtask

  // Monitor: compares the presented output with the queue head, pops on
  // an accepted output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        if (exp_q.size() == 0) begin
          check("out_valid_idle", out_valid, 0);
        end else begin
          check("out_valid", out_valid, 1);
          check("out_data", out_data, exp_q[0][DATA_W-1:0]);
          check("out_ch", out_ch, exp_q[0][W-1:DATA_W]);
`ifdef MUXN_PARITY_EN
          check("out_par", out_par, ^exp_q[0][DATA_W-1:0]);
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Asynchronous reset in the middle of a cycle, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    in_valid = 4'b1111;
    check("pre_rst_valid", out_valid, model_full);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_ready", in_ready, 0);
    exp_q.delete();
    model_full = 1'b0;
    model_ptr  = 0;
    @(negedge clk);
    #1;
    in_valid = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state with channels requesting
    in_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    in_valid = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 3-channel instance: ctrl_sel = 3 is out of range
    @(negedge clk);
    #1;
    mode3 = 1'b0; sel3 = 2'd1; valid3 = 3'b111; data3 = 24'h332211; or3 = 1'b1;
    #2;
    check("n3_ready_sel1", ready3, 3'b010);
    @(negedge clk);
    #1;
    sel3 = 2'd3;
    #2;
    check("n3_out_valid", ov3, 1);
    check("n3_out_data", od3, 8'h22);
    check("n3_out_ch", oc3, 1);
    check("n3_ready_sel3", ready3, 3'b000);
    @(negedge clk);
    #3;
    check("n3_drained", ov3, 0);
    valid3 = '0;

    // fixed select, channel 2
    drive_cycle(MODE_FIXED, 2, 4'b0100, 32'h00A5_0000, 1'b1);
    // round robin, all valid, wraps back to channel 0
    repeat (5) drive_cycle(MODE_RR, 0, 4'b1111, 32'h1312_1110, 1'b1);
    // backpressure for 3 cycles, then drain and load in one edge
    repeat (3) drive_cycle(MODE_RR, 0, 4'b1111, 32'h2322_2120, 1'b0);
    drive_cycle(MODE_RR, 0, 4'b1111, 32'h2322_2120, 1'b1);
    // parity sample, left in the register for the mid-stream reset
    drive_cycle(MODE_FIXED, 0, 4'b0001, 32'h0000_0007, 1'b1);
    do_reset();
    // pointer back at 0: sparse requests alternate 1,3,1,3
    repeat (4) drive_cycle(MODE_RR, 0, 4'b1010, 32'h4342_4140, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive_cycle(bit'($urandom_range(0, 1)), $urandom_range(0, NUM_CH - 1),
                  NUM_CH'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 3) != 0);
    end

    // drain
    repeat (3) drive_cycle(MODE_RR, 0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    #3;
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
